boot_loader: RTL and testbench

Streams a program image from a byte-wide host link into system RAM before the CPU runs, then releases the CPU. It is the write-side counterpart of the CPU's fetch/load path. It drives the same RAM port used by the memory controller (address, 32-bit data, RAM_RW), holds the core off the bus while loading, and replaces the simulation-only memory preload with a synthesizable path.

---
 rtl/boot_loader_if.sv | 23 ++
 rtl/boot_loader.sv | 97 +++++++++
 tb/tb_boot_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// boot_loader_if: host byte link plus the shared RAM write port
// master: the boot loader (takes host bytes, drives the RAM port)
// slave:  the environment (host byte source and RAM)
interface boot_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic ram_drive;
  logic ram_rw;
  modport master (
    input  byte_in, byte_valid,
    output byte_ready, ram_addr, ram_data, ram_drive, ram_rw
  );
  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, ram_addr, ram_data, ram_drive, ram_rw
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed, big-endian program image from a byte link into RAM, holding the CPU off the bus
// Ports: clk; reset (async, active-low); start (begin a load, sampled in IDLE);
//   bus (boot_loader_if.master): byte_in/byte_valid/byte_ready host link, ram_addr/ram_data/ram_drive/ram_rw RAM port;
//   cpu_hold, busy, done (1-cycle pulse), error (sticky checksum failure), word_count (words written this load).
// Option: define BOOT_CHECKSUM_EN to expect a trailing XOR checksum byte (CHECK state); otherwise error is tied low.
module boot_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  boot_loader_if.master bus,
  output logic cpu_hold,
  output logic busy,
  output logic done,
  output logic error,
  output logic [15:0] word_count
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, COLLECT, WRITE, CHECK, FINISH} state_t;
`ifdef BOOT_CHECKSUM_EN
  localparam state_t TAIL = CHECK;
`else
  localparam state_t TAIL = FINISH;
`endif
  state_t state, next;
  logic [15:0] len;
  logic [DATA_W-1:0] word;
  logic [1:0] cnt;
  logic fire, ok;
  assign bus.byte_ready = state inside {LEN_HI, LEN_LO, COLLECT, CHECK};
  assign fire = bus.byte_valid && bus.byte_ready;
  // The RAM port is only ever driven during WRITE; otherwise it idles at zero.
  assign bus.ram_rw = state == WRITE;
  assign bus.ram_drive = bus.ram_rw;
  assign bus.ram_addr = bus.ram_rw ? BASE_ADDR + ADDR_W'(word_count) : '0;
  assign bus.ram_data = bus.ram_rw ? word : '0;
  assign busy = !(state inside {IDLE, FINISH});
  assign done = state == FINISH;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LEN_HI : IDLE;
      LEN_HI:  next = fire ? LEN_LO : LEN_HI;
      LEN_LO:  next = !fire ? LEN_LO : ({len[15:8], bus.byte_in} == 16'd0) ? TAIL : COLLECT;
      COLLECT: next = (fire && cnt == 2'd3) ? WRITE : COLLECT;
      WRITE:   next = (word_count + 16'd1 == len) ? TAIL : COLLECT;
      CHECK:   next = fire ? FINISH : CHECK;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      len <= '0;
      word <= '0;
      cnt <= '0;
      cpu_hold <= 1'b0;
      word_count <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        cpu_hold <= 1'b1;
        word_count <= '0;
        cnt <= '0;
      end
      if (fire && state == LEN_HI) len[15:8] <= bus.byte_in;
      if (fire && state == LEN_LO) len[7:0] <= bus.byte_in;
      if (fire && state == COLLECT) begin
        word <= {word[DATA_W-9:0], bus.byte_in};
        cnt <= cnt + 2'd1;
      end
      if (state == WRITE) word_count <= word_count + 16'd1;
      // A failed checksum keeps the CPU stalled until the next start or reset.
      if (next == FINISH && state != FINISH && ok) cpu_hold <= 1'b0;
    end
`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;
  // csum covers every accepted byte including the length header.
  assign ok = !(state == CHECK && bus.byte_in != csum);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      csum <= '0;
      error <= 1'b0;
    end else if (state == IDLE && start) begin
      csum <= '0;
      error <= 1'b0;
    end else begin
      if (fire) csum <= csum ^ bus.byte_in;
      if (fire && !ok) error <= 1'b1;
    end
`else
  assign ok = 1'b1;
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table-driven, directed and randomized checks of boot_loader against a load-level reference model
module tb_boot_loader;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic hold0, busy0, done0, err0, hold1, busy1, done1, err1;
  logic [15:0] wc0, wc1;
  always #5 clk = ~clk;
  boot_loader_if b0 ();
  boot_loader_if b1 ();
  assign b0.byte_in = byte_in;
  assign b0.byte_valid = byte_valid;
  assign b1.byte_in = byte_in;
  assign b1.byte_valid = byte_valid;
  boot_loader dut0 (.clk(clk), .reset(reset), .start(start), .bus(b0), .cpu_hold(hold0),
                    .busy(busy0), .done(done0), .error(err0), .word_count(wc0));
  boot_loader #(.BASE_ADDR(16'hFFFF)) dut1 (.clk(clk), .reset(reset), .start(start), .bus(b1),
                    .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1), .word_count(wc1));

  int checks = 0, errors = 0;
  int cyc = 0, nwr = 0, bus_bad = 0, done_cyc = -1, last_acc = 0;
  logic hold_at_done, busy_at_done;
  logic [31:0] mem0 [int];
  logic [31:0] mem1 [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;
  // RAM models for both instances plus bus-discipline monitor
  always @(negedge clk) begin
    if (b0.ram_rw) begin
      mem0[int'(b0.ram_addr)] = b0.ram_data;
      mem1[int'(b1.ram_addr)] = b1.ram_data;
      nwr++;
    end
    if (b0.ram_drive !== b0.ram_rw || (b0.byte_ready && b0.ram_rw) ||
        {hold1, busy1, done1, err1, wc1, b1.byte_ready, b1.ram_rw, b1.ram_drive} !==
        {hold0, busy0, done0, err0, wc0, b0.byte_ready, b0.ram_rw, b0.ram_drive})
      bus_bad++;
    if (done0) begin
      done_cyc = cyc;
      hold_at_done = hold0;
      busy_at_done = busy0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) step();
    byte_in = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!b0.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("byte_ready_wait", 32'(n < 50), 32'd1);
    last_acc = cyc;
    step();
    byte_valid = 1'b0;
  endtask

  // Full load: the model derives N, words, addresses and done timing from the image bytes alone.
  task automatic run_load(input logic [7:0] img[$], input int maxgap, input bit bad_ck, input string tag);
    logic [7:0] x = 8'h00;
    int n, k = 0;
    logic [31:0] w;
    bit fail_ck;
    mem0.delete();
    mem1.delete();
    nwr = 0;
    bus_bad = 0;
    done_cyc = -1;
    go();
    foreach (img[i]) begin
      push(img[i], $urandom_range(0, maxgap));
      x ^= img[i];
    end
    fail_ck = CK && bad_ck;
    if (CK) push(bad_ck ? x ^ 8'h01 : x, $urandom_range(0, maxgap));
    while (done_cyc < 0 && k < 10) begin
      step();
      k++;
    end
    n = int'({img[0], img[1]});
    chk({tag, "_writes"}, nwr, n);
    for (int i = 0; i < n; i++) begin
      w = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
      chk($sformatf("%s_mem0_%0d", tag, i), mem0.exists(i & 'hFFFF) ? mem0[i & 'hFFFF] : 32'hx, w);
      chk($sformatf("%s_mem1_%0d", tag, i), mem1.exists((i + 'hFFFF) & 'hFFFF) ? mem1[(i + 'hFFFF) & 'hFFFF] : 32'hx, w);
    end
    chk({tag, "_done_cycle"}, done_cyc, last_acc + ((CK || n == 0) ? 1 : 2));
    chk({tag, "_hold_at_done"}, hold_at_done, fail_ck);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_word_count"}, wc0, n);
    chk({tag, "_hold_after"}, hold0, fail_ck);
    chk({tag, "_error"}, err0, fail_ck);
    chk({tag, "_busy_after"}, busy0, 0);
    chk({tag, "_bus"}, bus_bad, 0);
  endtask

  typedef struct {
    logic s, v;
    logic [7:0] b;
    logic r, bz, h, d, w;
  } vec_t;

  function automatic vec_t mk(logic s, logic v, logic [7:0] b, logic r, logic bz, logic h, logic d, logic w);
    vec_t t;
    t.s = s; t.v = v; t.b = b; t.r = r; t.bz = bz; t.h = h; t.d = d; t.w = w;
    return t;
  endfunction

  initial begin
    vec_t tv[$];
    logic [7:0] img[$];
    // Expected outputs during each cycle of a one-word load with stalls and a stray start
    tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0));
    tv.push_back(mk(1, 1, 8'h00, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'h01, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'hAA, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'hBB, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'hCC, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'hDD, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 8'hEE, 0, 1, 1, 0, 1));
    if (CK) tv.push_back(mk(0, 1, 8'h01, 1, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));

    // reset held with start and valid asserted
    start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {b0.byte_ready, b0.ram_rw, b0.ram_drive, hold0, busy0, done0, err0}, 0);
    chk("rst_addr", b0.ram_addr, 0);
    chk("rst_data", b0.ram_data, 0);
    chk("rst_wc", wc0, 0);
    start = 1'b0;
    byte_valid = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("post_rst_ready", b0.byte_ready, 0);
    chk("post_rst_busy", busy0, 0);

    mem0.delete();
    nwr = 0;
    foreach (tv[i]) begin
      start = tv[i].s;
      byte_valid = tv[i].v;
      byte_in = tv[i].b;
      @(negedge clk);
      chk($sformatf("tv%0d_ready", i), b0.byte_ready, tv[i].r);
      chk($sformatf("tv%0d_busy", i), busy0, tv[i].bz);
      chk($sformatf("tv%0d_hold", i), hold0, tv[i].h);
      chk($sformatf("tv%0d_done", i), done0, tv[i].d);
      chk($sformatf("tv%0d_rw", i), b0.ram_rw, tv[i].w);
      step();
    end
    start = 1'b0;
    byte_valid = 1'b0;
    chk("tv_mem", mem0.exists(0) ? mem0[0] : 32'hx, 32'hAABBCCDD);
    chk("tv_writes", nwr, 1);
    chk("tv_wc", wc0, 1);

    img = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    run_load(img, 0, 1'b0, "two_words");
    img = {8'h00, 8'h00};
    run_load(img, 0, 1'b0, "empty");
`ifdef BOOT_CHECKSUM_EN
    img = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load(img, 0, 1'b0, "ck_good");
    run_load(img, 0, 1'b1, "ck_bad");
`endif

    // reset in the middle of the second word
    mem0.delete();
    mem1.delete();
    nwr = 0;
    go();
    img = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    foreach (img[i]) push(img[i], 0);
    reset = 1'b0;
    #2;
    chk("midrst_ready", b0.byte_ready, 0);
    chk("midrst_hold", hold0, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_wc", wc0, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    chk("midrst_writes", nwr, 1);
    chk("midrst_word0", mem0.exists(0) ? mem0[0] : 32'hx, 32'hDEADBEEF);
    chk("midrst_no_word1", mem0.exists(1), 0);
    chk("midrst_wrap_word0", mem1.exists('hFFFF) ? mem1['hFFFF] : 32'hx, 32'hDEADBEEF);
    chk("midrst_idle", {b0.byte_ready, hold0, busy0}, 0);

    for (int r = 0; r < 16; r++) begin
      int n = $urandom_range(0, 5);
      img = {8'(n >> 8), 8'(n)};
      repeat (4 * n) img.push_back(8'($urandom));
      run_load(img, $urandom_range(0, 2), 1'($urandom), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
